// File: rtl/ped_crossing_if.sv
// Lamp and pedestrian signals between the traffic-light side and the crossing
// controller. master = traffic/pedestrian side, slave = ped_crossing.
interface ped_crossing_if;
  logic red;
  logic orange;
  logic green;
  logic button;
  logic walk;
  logic dont_walk;
  logic flash;
  logic wait_lamp;
  logic fault;

  modport master (
    output red, orange, green, button,
    input  walk, dont_walk, flash, wait_lamp, fault
  );

  modport slave (
    input  red, orange, green, button,
    output walk, dont_walk, flash, wait_lamp, fault
  );
endinterface

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller: grants WALK only on a red-rise from the
// upstream traffic FSM, then a flashing clearance; illegal lamps latch FAULT.
module ped_crossing #(
  parameter int WALK_CYCLES  = 4,
  parameter int FLASH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  ped_crossing_if.slave  bus
);

  localparam int MAX_CYCLES = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    WALK  = 3'd2,
    CLEAR = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          red_q;
  logic          walk_q, walk_d;
  logic          dw_q, dw_d;
  logic          flash_q, flash_d;
  logic          fault_q, fault_d;

  logic lamp_ok, red_rise, eff_req;

  // Exactly one lamp lit; none or several is treated as an upstream failure.
  assign lamp_ok  = (bus.red ^ bus.orange ^ bus.green) & ~(bus.red & bus.orange & bus.green);
  assign red_rise = bus.red & ~red_q;
  assign eff_req  = req_q | bus.button;

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      red_q   <= 1'b1;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      flash_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      red_q   <= bus.red;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      flash_q <= flash_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: each next-state variable defaults to its held value before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    walk_d  = walk_q;
    dw_d    = dw_q;
    flash_d = flash_q;
    fault_d = fault_q;

    if (!lamp_ok) begin
      state_d = FAULT;
      fault_d = 1'b1;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      flash_d = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ARMED: begin
          req_d = eff_req;
          // A press coinciding with the red-rise is granted on the same edge.
          if (eff_req && red_rise) begin
            state_d = WALK;
            cnt_d   = CW'(WALK_CYCLES - 1);
            walk_d  = 1'b1;
            dw_d    = 1'b0;
            req_d   = 1'b0;
          end else if (eff_req) begin
            state_d = ARMED;
          end
        end

        WALK: begin
          if (!bus.red || cnt_q == '0) begin
            state_d = CLEAR;
            cnt_d   = CW'(FLASH_CYCLES - 1);
            walk_d  = 1'b0;
            flash_d = 1'b1;
            dw_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        CLEAR: begin
          req_d = eff_req;
          if (cnt_q == '0) begin
            state_d = eff_req ? ARMED : IDLE;
            dw_d    = 1'b1;
            flash_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
            dw_d  = ~dw_q;
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d = FAULT;
          fault_d = 1'b1;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          flash_d = 1'b0;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.walk      = walk_q;
  assign bus.dont_walk = dw_q;
  assign bus.flash     = flash_q;
  assign bus.wait_lamp = req_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Directed bench for ped_crossing: expected lamp vectors are queued as stimulus
// is driven and popped after each clock edge.
module tb_ped_crossing;

  logic clk;
  logic reset;

  ped_crossing_if pif ();

  ped_crossing #(
    .WALK_CYCLES  (4),
    .FLASH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {walk, dont_walk, flash, wait_lamp, fault}
  typedef struct {
    string      tag;
    logic [4:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [4:0] O_IDLE  = 5'b01000;
  localparam logic [4:0] O_ARMED = 5'b01010;
  localparam logic [4:0] O_WALK  = 5'b10000;
  localparam logic [4:0] O_CLR1  = 5'b01100;
  localparam logic [4:0] O_CLR0  = 5'b00100;
  localparam logic [4:0] O_CLR0W = 5'b00110;
  localparam logic [4:0] O_FAULT = 5'b01001;

  function automatic logic [4:0] observed();
    return {pif.walk, pif.dont_walk, pif.flash, pif.wait_lamp, pif.fault};
  endfunction

  task automatic check();
    exp_t e;
    logic [4:0] o;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%b", observed());
    end else begin
      e = exp_q.pop_front();
      o = observed();
      checks++;
      assert (o === e.outs)
        else begin
          failures++;
          $error("FAIL %s observed=%b expected=%b (walk,dw,flash,wait,fault)", e.tag, o, e.outs);
        end
    end
  endtask

  // Drive lamps/button at the falling edge, then compare just after the rising edge.
  task automatic tick(input logic r, input logic o, input logic g, input logic b,
                      input logic [4:0] exp_outs, input string tag);
    exp_t e;
    @(negedge clk);
    pif.red    = r;
    pif.orange = o;
    pif.green  = g;
    pif.button = b;
    e.tag  = tag;
    e.outs = exp_outs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic push_now(input logic [4:0] exp_outs, input string tag);
    exp_t e;
    e.tag  = tag;
    e.outs = exp_outs;
    exp_q.push_back(e);
  endtask

  initial begin
    reset      = 1'b0;
    pif.red    = 1'b0;
    pif.orange = 1'b0;
    pif.green  = 1'b1;
    pif.button = 1'b0;
    #12;
    push_now(O_IDLE, "reset_state");
    check();
    @(negedge clk);
    reset = 1'b1;

    // Press, then green -> orange -> red held 8 edges
    tick(0, 0, 1, 1, O_ARMED, "press_latched");
    tick(0, 0, 1, 0, O_ARMED, "armed_green");
    tick(0, 1, 0, 0, O_ARMED, "armed_orange");
    tick(1, 0, 0, 0, O_WALK,  "walk_on_rise");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, O_WALK, "walk_hold");
    tick(1, 0, 0, 0, O_CLR1,  "clear_dw1");
    tick(1, 0, 0, 0, O_CLR0,  "clear_dw0");
    tick(1, 0, 0, 0, O_IDLE,  "idle_after_clear");
    tick(1, 0, 0, 0, O_IDLE,  "idle_red_steady");

    // Button exactly on the red-rise edge, no prior request
    tick(0, 0, 1, 0, O_IDLE,  "idle_green");
    tick(1, 0, 0, 1, O_WALK,  "same_edge_grant");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, O_WALK, "walk_hold2");
    tick(1, 0, 0, 0, O_CLR1,  "clear2_dw1");
    tick(1, 0, 0, 0, O_CLR0,  "clear2_dw0");
    tick(1, 0, 0, 0, O_IDLE,  "idle2");

    // Press while red already steady: no grant until the next red-rise
    tick(1, 0, 0, 1, O_ARMED, "press_red_steady");
    tick(1, 0, 0, 0, O_ARMED, "no_grant_steady_a");
    tick(1, 0, 0, 0, O_ARMED, "no_grant_steady_b");
    tick(0, 0, 1, 0, O_ARMED, "armed_wait_green");
    tick(1, 0, 0, 0, O_WALK,  "grant_next_rise");
    tick(1, 0, 0, 0, O_WALK,  "walk_second_edge");

    // Red drops mid-walk: abort into clearance, press during clearance
    tick(0, 0, 1, 0, O_CLR1,  "abort_clear");
    tick(0, 0, 1, 1, O_CLR0W, "press_in_clear");
    tick(0, 0, 1, 0, O_ARMED, "armed_after_clear");
    tick(0, 0, 1, 0, O_ARMED, "armed_hold");

    // Illegal lamps: sticky fault
    tick(1, 0, 1, 0, O_FAULT, "fault_red_green");
    tick(0, 0, 1, 0, O_FAULT, "fault_sticky_a");
    tick(1, 0, 0, 1, O_FAULT, "fault_sticky_b");
    tick(0, 0, 0, 0, O_FAULT, "fault_no_lamp");

    // Reset clears fault; then reset asserted asynchronously mid-walk
    @(negedge clk);
    reset = 1'b0;
    pif.red = 1'b0; pif.orange = 1'b0; pif.green = 1'b1; pif.button = 1'b0;
    #1;
    push_now(O_IDLE, "reset_clears_fault");
    check();
    @(negedge clk);
    reset = 1'b1;
    tick(0, 0, 1, 1, O_ARMED, "rearm");
    tick(1, 0, 0, 0, O_WALK,  "walk_before_reset");
    tick(1, 0, 0, 0, O_WALK,  "walk_before_reset2");
    #2;
    reset = 1'b0;
    #1;
    push_now(O_IDLE, "async_reset_mid_walk");
    check();
    @(negedge clk);
    reset = 1'b1;
    tick(1, 0, 0, 0, O_IDLE,  "red_high_after_reset");
    tick(1, 0, 0, 1, O_ARMED, "press_after_reset");
    tick(1, 0, 0, 0, O_ARMED, "no_grant_after_reset");
    tick(0, 0, 1, 0, O_ARMED, "armed_green_final");
    tick(1, 0, 0, 0, O_WALK,  "grant_final_rise");

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ped_crossing.md
# ped_crossing

Pedestrian crossing controller that sits directly downstream of the traffic-light FSM and consumes its one-hot red/orange/green lamp outputs. It latches pedestrian button requests and grants a WALK phase only at the start of a red phase. The WALK phase is followed by a flashing DON'T WALK clearance. Illegal lamp combinations from the upstream FSM force a sticky safe fault state.

## Interface
- WALK_CYCLES, 4: clock edges the walk lamp stays on; legal range is 1 or more.
- FLASH_CYCLES, 2: clock edges of flashing clearance; legal range is 1 or more.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- red  in  1  red lamp from the traffic FSM.
- orange  in  1  orange lamp from the traffic FSM.
- green  in  1  green lamp from the traffic FSM.
- button  in  1  pedestrian request, level sampled on each edge.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DON'T WALK lamp; lit during flashing only when flash=1.
- flash  out  1  high while in clearance, toggling.
- wait_lamp  out  1  request pending (pedestrian acknowledgment).
- fault  out  1  sticky illegal-lamp indication.

## Operation
- States:
  - IDLE: dont_walk steady.
  - ARMED: request latched.
  - WALK
  - CLEAR: flashing.
  - FAULT
- All outputs are registered. Reset values: walk=0, dont_walk=1, flash=0, wait_lamp=0, fault=0, state=IDLE, counter=0, red_q=1.
- red_q is the previous-edge sample of red. A red-rise is red=1 with red_q=0.
- Because red_q resets to 1, a red that is already high out of reset is not a rise.
- Request latch req:
  - Set on any edge with button=1 in IDLE, ARMED or CLEAR.
  - Ignored in WALK and FAULT.
  - Cleared on entry to WALK.
  - wait_lamp equals req.
- Effective request is req OR button, so a press on the same edge as a red-rise is granted.
- Transitions, in priority order:
  - Any state: if the lamp inputs are not exactly one-hot (including none or more than one high) -> FAULT. Set fault=1, walk=0, dont_walk=1, flash=0, req=0.
  - FAULT is left only by reset.
  - IDLE -> ARMED when req or button.
  - ARMED -> WALK on a red-rise. Load counter with WALK_CYCLES-1; walk=1, dont_walk=0.
  - A red that is already high in ARMED does not grant. The controller waits for the next red-rise (remaining red time is unknown).
  - WALK: if red=0 -> CLEAR early (abort, start clearance). Else decrement the counter; at 0 -> CLEAR.
  - Entry to CLEAR: counter=FLASH_CYCLES-1, walk=0, flash=1, dont_walk=1.
  - CLEAR: dont_walk toggles each edge and is AND-ed with phase (dont_walk = flash phase bit). Decrement the counter; at 0 -> ARMED if req else IDLE, with dont_walk=1 steady and flash=0.
- Counter width is $clog2(max(WALK_CYCLES, FLASH_CYCLES)+1). The counter never wraps: it is loaded on entry and stops at 0.

## Timing
- Grant latency: walk=1 is visible immediately after the edge that samples the red-rise (one edge).
- walk is high for exactly WALK_CYCLES clock periods when red stays high.
- Clearance: exactly FLASH_CYCLES periods with flash=1. dont_walk pattern starts 1,0,1,...
- Abort: if red falls during WALK, walk drops on the edge that samples red=0.
- Reset is asynchronous: any state snaps to reset values immediately on reset=0, mid-WALK included. Release is synchronous to the next edge.
- Fault detection takes 1 edge and overrides every other transition on that same edge.

## Test plan
- Reset mid-WALK: assert reset=0 asynchronously -> walk=0, dont_walk=1, wait_lamp=0 before the next edge. Red held high after release -> no grant.
- Press, then sequence green -> orange -> red with red held 8 cycles (WALK_CYCLES=4, FLASH_CYCLES=2):
  - wait_lamp=1 from the edge after the press.
  - walk=1 for 4 edges starting at the red-rise edge; wait_lamp=0.
  - flash=1 for 2 edges with dont_walk 1,0.
  - Then IDLE with dont_walk=1.
- Button pulsed on the exact red-rise edge with no prior request -> walk=1 on that edge.
- Press while red already steady -> no walk during this red. Walk is granted at the next red-rise.
- Red drops to green after 2 walk edges -> walk=0 on the next edge, then 2 clearance edges. A press during clearance -> ends in ARMED with wait_lamp=1.
- red=1 and green=1 together for 1 cycle -> fault=1, walk=0, dont_walk=1. fault stays 1 after inputs recover; only reset clears it.
